md_unit: RTL and testbench

//   Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.

---
 rtl/md_unit.sv | 144 ++++++++++++++
 tb/tb_md_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Define MD_MADD_EN to enable MADD/MSUB (op 6/7); otherwise those ops are no-ops.
module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MADD  = 3'd6,
      OP_MSUB  = 3'd7
   } op_e;

   typedef enum logic {ST_IDLE, ST_BUSY} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   op_e                op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

   logic [2*WIDTH-1:0] prod_s, prod_u, result;
   logic [WIDTH-1:0]   num, den, den_safe, uq, ur, quo, rem;
   logic               sgn_div, a_neg, b_neg;

   // Result datapath works on captured operands so the inputs may change while busy.
   // Division is done on magnitudes; MIN/-1 then wraps naturally to lo=MIN, hi=0.
   always_comb begin
      prod_s   = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
      prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
      sgn_div  = (op_q == OP_DIV);
      a_neg    = sgn_div & a_q[WIDTH-1];
      b_neg    = sgn_div & b_q[WIDTH-1];
      num      = a_neg ? -a_q : a_q;
      den      = b_neg ? -b_q : b_q;
      den_safe = (den == '0) ? WIDTH'(1) : den;
      uq       = num / den_safe;
      ur       = num % den_safe;
      quo      = (a_neg ^ b_neg) ? -uq : uq;
      rem      = a_neg ? -ur : ur;
      case (op_q)
         OP_MULT:          result = prod_s;
         OP_MULTU:         result = prod_u;
         OP_DIV, OP_DIVU:  result = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quo};
`ifdef MD_MADD_EN
         OP_MADD:          result = {hi_q, lo_q} + prod_s;
         OP_MSUB:          result = {hi_q, lo_q} - prod_s;
`endif
         default:          result = {hi_q, lo_q};
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d = op_e'(op);
               a_d  = a;
               b_d  = b;
               case (op_e'(op))
                  OP_MULT, OP_MULTU: begin
                     state_d = ST_BUSY;
                     cnt_d   = CW'(MULT_CYCLES - 1);
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d = ST_BUSY;
                     cnt_d   = CW'(DIV_CYCLES - 1);
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
`ifdef MD_MADD_EN
                  OP_MADD, OP_MSUB: begin
                     state_d = ST_BUSY;
                     cnt_d   = CW'(MULT_CYCLES - 1);
                  end
`endif
                  default: ;
               endcase
            end
         end
         ST_BUSY: begin
            // Counter reaches zero on the edge that retires the operation.
            if (cnt_q == '0) begin
               state_d      = ST_IDLE;
               {hi_d, lo_d} = result;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_MULT;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == ST_BUSY);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver queues expected HI/LO/latency, a monitor
// watches accepts, busy and reset edges and compares as results appear.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
      bit          is_rst;
   } exp_t;

   exp_t sb[$];

   md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op),
      .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: actual=event required=none", nm);
   endtask

   function automatic bit is_long(input logic [2:0] o);
`ifdef MD_MADD_EN
      return (o <= 3'd3) || (o >= 3'd6);
`else
      return (o <= 3'd3);
`endif
   endfunction

   task automatic push_exp(input string nm, input logic [31:0] eh, input logic [31:0] el,
                           input int cyc, input bit rst);
      exp_t e;
      e.name = nm; e.hi = eh; e.lo = el; e.cyc = cyc; e.is_rst = rst;
      sb.push_back(e);
   endtask

   // Drives one request at posedge+2, holds start across one edge, then scrambles inputs.
   task automatic applyStimulus(input string nm, input logic [2:0] o, input logic [31:0] va,
                                input logic [31:0] vb, input logic [31:0] eh,
                                input logic [31:0] el, input int cyc);
      int n;
      push_exp(nm, eh, el, cyc, 1'b0);
      start = 1'b1; op = o; a = va; b = vb;
      @(posedge clk); #2;
      start = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D; op = 3'd4;
      n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #2;
   endtask

   // Monitor: decides what happened at each edge from inputs seen the half-cycle before.
   initial begin : monitor
      exp_t        e;
      bit          inflight;
      int          icnt;
      bit          p_acc, p_rst;
      logic [2:0]  p_op;
      inflight = 0; icnt = 0; p_acc = 0; p_rst = 0; p_op = '0;
      forever begin
         @(negedge clk);
         if (p_rst) begin
            inflight = 0;
            if (sb.size() > 0 && sb[0].is_rst) begin
               e = sb.pop_front();
               chk({e.name, " busy"}, {63'b0, busy}, 64'd0);
               chk({e.name, " hi"}, {32'b0, hi}, {32'b0, e.hi});
               chk({e.name, " lo"}, {32'b0, lo}, {32'b0, e.lo});
            end
         end else if (p_acc) begin
            if (is_long(p_op)) begin
               inflight = 1;
               icnt     = 0;
            end else if (sb.size() == 0) begin
               fail_now("unexpected immediate accept");
            end else begin
               e = sb.pop_front();
               chk({e.name, " busy"}, {63'b0, busy}, 64'd0);
               chk({e.name, " hi"}, {32'b0, hi}, {32'b0, e.hi});
               chk({e.name, " lo"}, {32'b0, lo}, {32'b0, e.lo});
            end
         end
         if (inflight) begin
            if (busy === 1'b1) begin
               icnt++;
               if (icnt > 200) begin
                  fail_now("busy timeout");
                  inflight = 0;
               end
            end else begin
               inflight = 0;
               if (sb.size() == 0) begin
                  fail_now("unexpected completion");
               end else begin
                  e = sb.pop_front();
                  chk({e.name, " cycles"}, 64'(icnt), 64'(e.cyc));
                  chk({e.name, " hi"}, {32'b0, hi}, {32'b0, e.hi});
                  chk({e.name, " lo"}, {32'b0, lo}, {32'b0, e.lo});
               end
            end
         end
         p_rst = (reset_n === 1'b0);
         p_acc = (reset_n === 1'b1) && (start === 1'b1) && (busy === 1'b0);
         p_op  = op;
      end
   end

   task automatic checkOutput(input string nm, input logic [31:0] eh, input logic [31:0] el);
      chk({nm, " busy"}, {63'b0, busy}, 64'd0);
      chk({nm, " hi"}, {32'b0, hi}, {32'b0, eh});
      chk({nm, " lo"}, {32'b0, lo}, {32'b0, el});
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : driver
      reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      push_exp("reset", 32'h0, 32'h0, 0, 1'b1);
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk); #2;

      applyStimulus("mult -2*3",   3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      applyStimulus("multu -2*3",  3'd1, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5);
      applyStimulus("mult -1*-1",  3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 5);
      applyStimulus("multu max^2", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 5);
      applyStimulus("div -7/2",    3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      applyStimulus("divu 7/2",    3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10);
      applyStimulus("div 7/-2",    3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10);
      applyStimulus("divu x/0",    3'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 10);
      applyStimulus("div -5/0",    3'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 10);
      applyStimulus("div ovf",     3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);

      // MULT then MTLO held on start through busy; only the E6 request may take effect.
      push_exp("mult 4*5", 32'h0, 32'd20, 5, 1'b0);
      push_exp("mtlo at E6", 32'h0, 32'd9, 0, 1'b0);
      start = 1'b1; op = 3'd0; a = 32'd4; b = 32'd5;
      @(posedge clk); #2;
      op = 3'd5; a = 32'd9; b = 32'd0;
      repeat (6) @(posedge clk);
      #2 start = 1'b0;
      @(posedge clk); #2;

      applyStimulus("mthi", 3'd4, 32'h0000ABCD, 32'd0, 32'h0000ABCD, 32'd9, 0);

      // Reset lands at E3 of a divide with start asserted; the divide must never retire.
      push_exp("reset mid div", 32'h0, 32'h0, 0, 1'b1);
      start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b0; start = 1'b1; op = 3'd0;
      @(posedge clk); #2;
      reset_n = 1'b1; start = 1'b0;
      repeat (12) @(posedge clk);
      #2 checkOutput("no late writeback", 32'h0, 32'h0);

      applyStimulus("mthi 0",  3'd4, 32'd0, 32'd0, 32'h0, 32'h0, 0);
      applyStimulus("mtlo 10", 3'd5, 32'd10, 32'd0, 32'h0, 32'd10, 0);
`ifdef MD_MADD_EN
      applyStimulus("madd -1*3", 3'd6, 32'hFFFFFFFF, 32'd3, 32'h0, 32'd7, 5);
      applyStimulus("msub 2*5",  3'd7, 32'd2, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFD, 5);
`else
      applyStimulus("op6 noop", 3'd6, 32'hFFFFFFFF, 32'd3, 32'h0, 32'd10, 0);
      applyStimulus("op7 noop", 3'd7, 32'd2, 32'd5, 32'h0, 32'd10, 0);
`endif

      repeat (5) @(posedge clk);
      chk("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
